// File: rtl/acc_cpu_core.sv
// 8-bit accumulator core: instruction RAM, two-cycle fetch controller, and a strobe-driven datapath.
// Define ACC_CPU_PC_OUT_EN to export the program counter (PC_out) and fetch state (fetch_state).
module acc_cpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  CPUinput,
  output logic [7:0]  CPUoutput,
  input  logic        ACCld_str,
  input  logic        ACCinMUXselect,
  input  logic        shiftercontrol,
  input  logic        ALUinMUXselect,
  input  logic        ALUcontrol_in,
  input  logic        DataRAMenable,
  input  logic        DRAMaddrMUXselect,
  input  logic        DataRAMread_en,
  input  logic        IndirectAddrRegld_str,
  input  logic        StageRegclr,
  input  logic        InstrRAMclear,
  input  logic [7:0]  addrin,
  input  logic [15:0] prog_data,
  input  logic        prog_we,
  output logic [15:0] IRAM_data_out,
  output logic [4:0]  StageRegInstr_out,
  output logic [2:0]  StageRegAddrMode_out,
  output logic [7:0]  StageRegData_out
`ifdef ACC_CPU_PC_OUT_EN
  ,
  output logic [7:0]  PC_out,
  output logic [1:0]  fetch_state
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    INC  = 2'd2
  } fetchState_t;

  fetchState_t fetchState;

  logic [15:0] instrRam [256];
  logic [7:0]  dataRam  [256];

  logic [7:0]  pc;
  logic [15:0] stageReg;
  logic [7:0]  acc;
  logic [7:0]  indirectAddr;
  logic [7:0]  dramAddr;
  logic [7:0]  dramRdata;
  logic [7:0]  aluB;
  logic [7:0]  aluResult;
  logic [7:0]  shifterOut;
  logic        dramRead;
  logic        dramWrite;

  // Instruction RAM: the bulk clear outranks a program-load write.
  always_ff @(posedge clk) begin
    if (!InstrRAMclear) begin
      for (int i = 0; i < 256; i++) instrRam[i] <= '0;
    end else if (prog_we) begin
      instrRam[addrin] <= prog_data;
    end
  end

  assign IRAM_data_out = instrRam[pc];

  // Fetch controller: a program-load cycle parks the FSM in IDLE without touching PC or stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetchState <= IDLE;
      pc         <= '0;
      stageReg   <= '0;
    end else begin
      if (prog_we) begin
        fetchState <= IDLE;
      end else begin
        case (fetchState)
          IDLE: fetchState <= LOAD;
          LOAD: begin
            stageReg   <= instrRam[pc];
            fetchState <= INC;
          end
          INC: begin
            pc         <= pc + 8'd1;
            fetchState <= LOAD;
          end
          default: fetchState <= IDLE;
        endcase
      end
      if (!StageRegclr) stageReg <= '0;
    end
  end

  assign StageRegInstr_out    = stageReg[15:11];
  assign StageRegAddrMode_out = stageReg[10:8];
  assign StageRegData_out     = stageReg[7:0];

  assign dramRead   = DataRAMenable && DataRAMread_en;
  assign dramWrite  = DataRAMenable && !DataRAMread_en;
  assign dramAddr   = DRAMaddrMUXselect ? indirectAddr : stageReg[7:0];
  assign dramRdata  = dramRead ? dataRam[dramAddr] : 8'h00;
  assign aluB       = ALUinMUXselect ? dramRdata : stageReg[7:0];
  assign aluResult  = ALUcontrol_in ? (acc - aluB) : (acc + aluB);
  assign shifterOut = shiftercontrol ? {aluResult[6:0], 1'b0} : aluResult;

  // The RAM write samples acc before this edge's accumulator load lands.
  always_ff @(posedge clk) begin
    if (dramWrite) dataRam[dramAddr] <= acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc          <= '0;
      indirectAddr <= '0;
    end else begin
      if (ACCld_str) acc <= ACCinMUXselect ? CPUinput : shifterOut;
      if (IndirectAddrRegld_str) indirectAddr <= dramRdata;
    end
  end

  assign CPUoutput = acc;

`ifdef ACC_CPU_PC_OUT_EN
  assign PC_out      = pc;
  assign fetch_state = fetchState;
`endif

endmodule

// File: tb/tb_acc_cpu_core.sv
// Bench for acc_cpu_core: directed scenarios plus random strobes, all checked against
// an array-based reference model that counts fetch edges after each program load.
module tb_acc_cpu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  CPUinput;
  logic [7:0]  CPUoutput;
  logic        ACCld_str;
  logic        ACCinMUXselect;
  logic        shiftercontrol;
  logic        ALUinMUXselect;
  logic        ALUcontrol_in;
  logic        DataRAMenable;
  logic        DRAMaddrMUXselect;
  logic        DataRAMread_en;
  logic        IndirectAddrRegld_str;
  logic        StageRegclr;
  logic        InstrRAMclear;
  logic [7:0]  addrin;
  logic [15:0] prog_data;
  logic        prog_we;
  logic [15:0] IRAM_data_out;
  logic [4:0]  StageRegInstr_out;
  logic [2:0]  StageRegAddrMode_out;
  logic [7:0]  StageRegData_out;

  acc_cpu_core dut (
    .clk(clk), .reset(reset), .CPUinput(CPUinput), .CPUoutput(CPUoutput),
    .ACCld_str(ACCld_str), .ACCinMUXselect(ACCinMUXselect), .shiftercontrol(shiftercontrol),
    .ALUinMUXselect(ALUinMUXselect), .ALUcontrol_in(ALUcontrol_in),
    .DataRAMenable(DataRAMenable), .DRAMaddrMUXselect(DRAMaddrMUXselect),
    .DataRAMread_en(DataRAMread_en), .IndirectAddrRegld_str(IndirectAddrRegld_str),
    .StageRegclr(StageRegclr), .InstrRAMclear(InstrRAMclear), .addrin(addrin),
    .prog_data(prog_data), .prog_we(prog_we), .IRAM_data_out(IRAM_data_out),
    .StageRegInstr_out(StageRegInstr_out), .StageRegAddrMode_out(StageRegAddrMode_out),
    .StageRegData_out(StageRegData_out)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  logic [15:0] mIram [256];
  logic [7:0]  mDram [256];
  bit          mValid [256];
  int          mAcc, mPc, mInd, runEdges;
  logic [15:0] mStage;
  bit          armed = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic checkAll();
    checkVal("acc", 16'(CPUoutput), 16'(mAcc));
    checkVal("iram", IRAM_data_out, mIram[mPc]);
    checkVal("instr", 16'(StageRegInstr_out), 16'(mStage[15:11]));
    checkVal("mode", 16'(StageRegAddrMode_out), 16'(mStage[10:8]));
    checkVal("data", 16'(StageRegData_out), 16'(mStage[7:0]));
  endtask

  // Advance the model by one edge using the inputs now applied, then clock the DUT.
  task automatic step();
    int addr, rd, b, r;
    addr = DRAMaddrMUXselect ? mInd : int'(mStage[7:0]);
    rd   = (DataRAMenable && DataRAMread_en) ? int'(mDram[addr]) : 0;
    b    = ALUinMUXselect ? rd : int'(mStage[7:0]);
    r    = ALUcontrol_in ? mAcc - b : mAcc + b;
    r    = (r + 256) % 256;
    if (shiftercontrol) r = (r * 2) % 256;
    if (DataRAMenable && !DataRAMread_en) begin
      mDram[addr]  = mAcc[7:0];
      mValid[addr] = 1'b1;
    end
    if (!reset) begin
      mAcc = 0; mPc = 0; mInd = 0; mStage = '0; runEdges = 0;
    end else begin
      if (ACCld_str) mAcc = ACCinMUXselect ? int'(CPUinput) : r;
      if (IndirectAddrRegld_str) mInd = rd;
      if (prog_we) runEdges = 0;
      else begin
        runEdges++;
        if (runEdges >= 2 && runEdges % 2 == 0) mStage = mIram[mPc];
        else if (runEdges >= 3) mPc = (mPc + 1) % 256;
      end
      if (!StageRegclr) mStage = '0;
    end
    if (!InstrRAMclear) begin
      foreach (mIram[i]) mIram[i] = '0;
    end else if (prog_we) begin
      mIram[addrin] = prog_data;
    end
    @(posedge clk);
    @(negedge clk);
    if (armed) checkAll();
  endtask

  // Driver tasks
  task automatic quietCtl();
    ACCld_str = 0; ACCinMUXselect = 0; shiftercontrol = 0; ALUinMUXselect = 0;
    ALUcontrol_in = 0; DataRAMenable = 0; DRAMaddrMUXselect = 0; DataRAMread_en = 0;
    IndirectAddrRegld_str = 0;
  endtask

  task automatic setAcc(input logic [7:0] v);
    CPUinput = v; ACCinMUXselect = 1; ACCld_str = 1;
    step();
    quietCtl();
  endtask

  task automatic aluOp(input logic sub, input logic shl, input logic fromRam, input logic viaInd);
    ALUcontrol_in = sub; shiftercontrol = shl; ALUinMUXselect = fromRam;
    DataRAMenable = fromRam; DataRAMread_en = 1; DRAMaddrMUXselect = viaInd;
    ACCinMUXselect = 0; ACCld_str = 1;
    step();
    quietCtl();
  endtask

  task automatic dramWr(input logic viaInd);
    DataRAMenable = 1; DataRAMread_en = 0; DRAMaddrMUXselect = viaInd;
    step();
    quietCtl();
  endtask

  task automatic progWrite(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1; addrin = a; prog_data = d;
    step();
  endtask

  initial begin
    mAcc = 0; mPc = 0; mInd = 0; mStage = '0; runEdges = 0;
    quietCtl();
    CPUinput = 0; addrin = 0; prog_data = 0; prog_we = 0;
    StageRegclr = 1; InstrRAMclear = 0; reset = 0;
    @(negedge clk);
    step(); step();
    armed = 1'b1;
    InstrRAMclear = 1; reset = 1;
    checkVal("rst_acc", 16'(CPUoutput), 16'h0000);
    checkVal("rst_instr", 16'(StageRegInstr_out), 16'h0000);
    checkVal("rst_mode", 16'(StageRegAddrMode_out), 16'h0000);
    checkVal("rst_data", 16'(StageRegData_out), 16'h0000);
    checkVal("rst_iram", IRAM_data_out, 16'h0000);

    // Program load and fetch
    progWrite(8'h00, 16'h8A05);
    progWrite(8'h01, 16'h1234);
    prog_we = 0;
    step(); step();
    checkVal("fetch0_instr", 16'(StageRegInstr_out), 16'h0011);
    checkVal("fetch0_mode", 16'(StageRegAddrMode_out), 16'h0002);
    checkVal("fetch0_data", 16'(StageRegData_out), 16'h0005);
    step(); step();
    checkVal("fetch1_data", 16'(StageRegData_out), 16'h0034);
    checkVal("fetch1_instr", 16'(StageRegInstr_out), 16'h0002);
    checkVal("fetch1_mode", 16'(StageRegAddrMode_out), 16'h0002);

    // Re-fetch IRAM[0] and park the fetcher so stage data stays 0x05
    reset = 0; step(); reset = 1;
    step(); step();
    prog_we = 1; addrin = 8'h80; prog_data = 16'h0000;
    step();
    checkVal("park_data", 16'(StageRegData_out), 16'h0005);

    // Accumulator path
    setAcc(8'h0F);
    checkVal("acc_in", 16'(CPUoutput), 16'h000F);
    aluOp(0, 0, 0, 0);
    checkVal("acc_add", 16'(CPUoutput), 16'h0014);
    setAcc(8'h0F);
    aluOp(1, 0, 0, 0);
    checkVal("acc_sub", 16'(CPUoutput), 16'h000A);
    setAcc(8'h0F);
    aluOp(0, 1, 0, 0);
    checkVal("acc_shl", 16'(CPUoutput), 16'h0028);

    // Data RAM direct and indirect
    setAcc(8'h40);
    dramWr(0);
    DataRAMenable = 1; DataRAMread_en = 1; IndirectAddrRegld_str = 1;
    step();
    quietCtl();
    setAcc(8'h77);
    dramWr(1);
    setAcc(8'h00);
    aluOp(0, 0, 1, 1);
    checkVal("dram_ind", 16'(CPUoutput), 16'h0077);

    // Same-edge RAM write and ACC load: the RAM must get the old ACC
    setAcc(8'h5A);
    DataRAMenable = 1; DataRAMread_en = 0; CPUinput = 8'hC3; ACCinMUXselect = 1; ACCld_str = 1;
    step();
    quietCtl();
    setAcc(8'h00);
    aluOp(0, 0, 1, 0);
    checkVal("wr_old_acc", 16'(CPUoutput), 16'h005A);

    // Overflow / underflow
    setAcc(8'h02);
    dramWr(0);
    setAcc(8'hFF);
    aluOp(0, 0, 1, 0);
    checkVal("acc_wrap_add", 16'(CPUoutput), 16'h0001);
    setAcc(8'h01);
    dramWr(0);
    setAcc(8'h00);
    aluOp(1, 0, 1, 0);
    checkVal("acc_wrap_sub", 16'(CPUoutput), 16'h00FF);

    // PC wrap 255 -> 0
    progWrite(8'hFF, 16'hABCD);
    prog_we = 0;
    for (int i = 0; i < 700 && mPc != 255; i++) step();
    checkVal("pc_at_255", IRAM_data_out, 16'hABCD);
    for (int i = 0; i < 4 && mPc != 0; i++) step();
    checkVal("pc_wrap", IRAM_data_out, 16'h8A05);

    // Stage clear across a capture edge
    StageRegclr = 0;
    step(); step();
    checkVal("sclr_instr", 16'(StageRegInstr_out), 16'h0000);
    checkVal("sclr_data", 16'(StageRegData_out), 16'h0000);
    StageRegclr = 1;

    // Instruction RAM clear, observed at several PCs
    InstrRAMclear = 0;
    step();
    InstrRAMclear = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checkVal("iram_clr", IRAM_data_out, 16'h0000);
    end

    // Reset mid-fetch
    progWrite(8'h00, 16'h1111);
    prog_we = 0;
    for (int i = 0; i < 5; i++) step();
    reset = 0;
    step();
    checkVal("rst_mid_pc", IRAM_data_out, 16'h1111);
    reset = 1;
    step(); step();
    checkVal("rst_mid_fetch", 16'(StageRegInstr_out), 16'h0002);

    // Random strobes
    for (int i = 0; i < 500; i++) begin
      int addr;
      reset                 = ($urandom_range(0, 49) != 0);
      prog_we               = ($urandom_range(0, 7) == 0);
      InstrRAMclear         = ($urandom_range(0, 99) != 0);
      StageRegclr           = ($urandom_range(0, 9) != 0);
      addrin                = 8'($urandom_range(0, 255));
      prog_data             = 16'($urandom_range(0, 65535));
      CPUinput              = 8'($urandom_range(0, 255));
      ACCld_str             = 1'($urandom_range(0, 1));
      ACCinMUXselect        = 1'($urandom_range(0, 1));
      shiftercontrol        = 1'($urandom_range(0, 1));
      ALUinMUXselect        = 1'($urandom_range(0, 1));
      ALUcontrol_in         = 1'($urandom_range(0, 1));
      DataRAMenable         = 1'($urandom_range(0, 1));
      DRAMaddrMUXselect     = 1'($urandom_range(0, 1));
      DataRAMread_en        = 1'($urandom_range(0, 1));
      IndirectAddrRegld_str = 1'($urandom_range(0, 1));
      addr = DRAMaddrMUXselect ? mInd : int'(mStage[7:0]);
      if (DataRAMenable && DataRAMread_en && !mValid[addr]) DataRAMread_en = 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
